// File: rtl/std_div_issue.sv
// Operand FIFO + go/done sequencer for std_div_pipe. Issue one cycle after head is eligible, result one edge after div_done.
// Zero divisors bypass the divider. A stalled result slot blocks issue while the FIFO keeps filling until full.
module std_div_issue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_div0,
  output logic             div_go,
  output logic [WIDTH-1:0] div_left,
  output logic [WIDTH-1:0] div_right,
  input  logic [WIDTH-1:0] div_out,
  input  logic             div_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             div_go_q, div_go_d;
  logic [WIDTH-1:0] div_left_q, div_left_d, div_right_q, div_right_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_div0_q, out_div0_d;

  logic [WIDTH-1:0] left_mem  [DEPTH];
  logic [WIDTH-1:0] right_mem [DEPTH];

  logic             push, pop, empty, slot_free;
  logic [WIDTH-1:0] head_left, head_right;

  assign in_ready   = (count_q != FULL_CNT);
  assign empty      = (count_q == '0);
  assign push       = in_valid && in_ready;
  assign slot_free  = !out_valid_q || out_ready;
  assign head_left  = left_mem[rd_ptr_q];
  assign head_right = right_mem[rd_ptr_q];

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_div0  = out_div0_q;
  assign div_go    = div_go_q;
  assign div_left  = div_left_q;
  assign div_right = div_right_q;

  // Storage needs no reset: the occupancy counter decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      left_mem[wr_ptr_q]  <= in_left;
      right_mem[wr_ptr_q] <= in_right;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_go_d    = div_go_q;
    div_left_d  = div_left_q;
    div_right_d = div_right_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_div0_d  = out_div0_q;
    pop         = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && slot_free) begin
          if (head_right != '0) begin
            div_left_d  = head_left;
            div_right_d = head_right;
            div_go_d    = 1'b1;
            state_d     = BUSY;
          end else begin
            pop         = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = '1;
            out_div0_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        // The slot was free at issue and nothing else loads it while busy.
        if (div_done) begin
          pop         = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = div_out;
          out_div0_d  = 1'b0;
          div_go_d    = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      div_go_q    <= 1'b0;
      div_left_q  <= '0;
      div_right_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_div0_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      div_go_q    <= div_go_d;
      div_left_q  <= div_left_d;
      div_right_q <= div_right_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_div0_q  <= out_div0_d;
    end
  end

endmodule

// File: tb/tb_std_div_issue.sv
// Bench for std_div_issue with a behavioural go/done divider and a result scoreboard.
module tb_std_div_issue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_left = '0;
  logic [7:0] in_right = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_div0;
  logic       div_go;
  logic [7:0] div_left, div_right;
  logic [7:0] div_out;
  logic       div_done;

  int n_checks = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  always #5 clk = ~clk;

  std_div_issue #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_div0(out_div0),
    .div_go(div_go), .div_left(div_left), .div_right(div_right),
    .div_out(div_out), .div_done(div_done)
  );

  // Divider model: starts on go, finishes after 1..4 cycles, holds done until go drops.
  logic       m_busy;
  int         m_cnt;
  logic [7:0] m_l, m_r;
  int         op_count = 0;
  int         drop_err = 0;
  int         stab_err = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy   <= 1'b0;
      div_done <= 1'b0;
      div_out  <= '0;
      m_cnt    <= 0;
    end else if (!div_go) begin
      if (m_busy) drop_err <= drop_err + 1;
      m_busy   <= 1'b0;
      div_done <= 1'b0;
    end else if (!m_busy && !div_done) begin
      m_busy   <= 1'b1;
      m_cnt    <= $urandom_range(1, 4);
      m_l      <= div_left;
      m_r      <= div_right;
      op_count <= op_count + 1;
    end else if (m_busy) begin
      if (div_left !== m_l || div_right !== m_r) stab_err <= stab_err + 1;
      if (m_cnt == 1) begin
        m_busy   <= 1'b0;
        div_done <= 1'b1;
        div_out  <= (m_r == 0) ? 8'h00 : m_l / m_r;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk)
    if (!reset && out_valid && out_ready) obs_q.push_back({out_div0, out_data});

  function automatic logic [8:0] expect_of(input logic [7:0] l, input logic [7:0] r);
    return (r == 0) ? {1'b1, 8'hFF} : {1'b0, l / r};
  endfunction

  task automatic send(input logic [7:0] l, input logic [7:0] r, output int waited);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_accept: in_ready=0 after %0d cycles, required 1", waited);
    end else begin
      exp_q.push_back(expect_of(l, r));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int b = 0;
    while (obs_q.size() < n && b < 500) begin
      @(negedge clk);
      b++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_checks += 7;
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    if (out_div0 !== 1'b0)  begin n_fail++; $display("FAIL reset_out_div0: got %b want 0", out_div0); end
    if (div_go !== 1'b0)    begin n_fail++; $display("FAIL reset_div_go: got %b want 0", div_go); end
    if (div_left !== 8'h00) begin n_fail++; $display("FAIL reset_div_left: got %h want 00", div_left); end
    if (div_right !== 8'h00) begin n_fail++; $display("FAIL reset_div_right: got %h want 00", div_right); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divide;
    int w, b, ops0;
    bit ok;
    logic [8:0] e, o;
    out_ready = 1'b1;
    ops0 = op_count;
    send(8'd100, 8'd7, w);
    n_checks++;
    if (div_go !== 1'b0) begin n_fail++; $display("FAIL div_go_early: got %b want 0", div_go); end
    @(negedge clk);
    n_checks += 3;
    if (div_go !== 1'b1) begin n_fail++; $display("FAIL div_issue_latency: div_go=%b want 1", div_go); end
    if (div_left !== 8'd100) begin n_fail++; $display("FAIL div_left: got %0d want 100", div_left); end
    if (div_right !== 8'd7) begin n_fail++; $display("FAIL div_right: got %0d want 7", div_right); end
    b = 0;
    while (!out_valid && b < 20) begin
      @(negedge clk);
      b++;
    end
    n_checks += 4;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL div_done_timeout: out_valid=%b want 1", out_valid); end
    if (out_data !== 8'd14) begin n_fail++; $display("FAIL div_quotient: got %0d want 14", out_data); end
    if (out_div0 !== 1'b0) begin n_fail++; $display("FAIL div_flag: got %b want 0", out_div0); end
    if (div_go !== 1'b0) begin n_fail++; $display("FAIL div_go_after_done: got %b want 0", div_go); end
    wait_obs(1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL divide_result_timeout: got %0d results want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL divide_result: got %h want %h", o, e); end
    end
    n_checks++;
    if (op_count - ops0 != 1) begin n_fail++; $display("FAIL divide_ops: got %0d want 1", op_count - ops0); end
  endtask

  task automatic test_div0;
    int w, ops0;
    bit ok;
    logic [8:0] e, o;
    out_ready = 1'b1;
    ops0 = op_count;
    send(8'd9, 8'd0, w);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL div0_early: out_valid=%b want 0", out_valid); end
    @(negedge clk);
    n_checks += 4;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL div0_latency: out_valid=%b want 1", out_valid); end
    if (out_data !== 8'hFF) begin n_fail++; $display("FAIL div0_data: got %h want ff", out_data); end
    if (out_div0 !== 1'b1) begin n_fail++; $display("FAIL div0_flag: got %b want 1", out_div0); end
    if (div_go !== 1'b0) begin n_fail++; $display("FAIL div0_go: got %b want 0", div_go); end
    wait_obs(1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL div0_result_timeout: got %0d results want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL div0_result: got %h want %h", o, e); end
    end
    n_checks++;
    if (op_count != ops0) begin n_fail++; $display("FAIL div0_ops: got %0d want 0", op_count - ops0); end
  endtask

  task automatic test_mix;
    logic [7:0] ls [4] = '{8'd20, 8'd5, 8'd255, 8'd0};
    logic [7:0] rs [4] = '{8'd3, 8'd0, 8'd16, 8'd9};
    int w, ops0;
    bit ok;
    logic [8:0] e, o;
    out_ready = 1'b1;
    ops0 = op_count;
    for (int i = 0; i < 4; i++) send(ls[i], rs[i], w);
    wait_obs(4, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mix_timeout: got %0d results want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mix_result: got %h want %h", o, e); end
    end
    n_checks++;
    if (op_count - ops0 != 3) begin n_fail++; $display("FAIL mix_ops: got %0d want 3", op_count - ops0); end
  endtask

  task automatic test_stall;
    logic [7:0] ls [5] = '{8'd200, 8'd33, 8'd7, 8'd128, 8'd99};
    logic [7:0] rs [5] = '{8'd10, 8'd4, 8'd0, 8'd2, 8'd9};
    int w, ops0;
    bit ok;
    logic [8:0] e, o;
    out_ready = 1'b0;
    ops0 = op_count;
    for (int i = 0; i < 5; i++) send(ls[i], rs[i], w);
    repeat (10) @(negedge clk);
    n_checks += 5;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
    if (out_data !== 8'd20) begin n_fail++; $display("FAIL stall_out_data: got %0d want 20", out_data); end
    if (div_go !== 1'b0) begin n_fail++; $display("FAIL stall_div_go: got %b want 0", div_go); end
    if (op_count - ops0 != 1) begin n_fail++; $display("FAIL stall_ops: got %0d want 1", op_count - ops0); end
    out_ready = 1'b1;
    wait_obs(5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_drain_timeout: got %0d results want 5", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL stall_result: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back;
    int w, stalls;
    bit ok;
    logic [8:0] e, o;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i), 8'd0, w);
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL occ3_in_ready: got %b want 1", in_ready); end
    // Occupancy 3 with bypass pops every cycle: each push must be accepted without waiting.
    out_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      send(8'(i + 40), 8'd0, w);
      stalls += w;
    end
    n_checks++;
    if (stalls != 0) begin n_fail++; $display("FAIL occ3_stalls: got %0d want 0", stalls); end
    fork
      for (int i = 0; i < 12; i++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)), w);
      repeat (60) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    wait_obs(28, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got %0d results want 28", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_result: got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_busy;
    int w, b;
    bit ok;
    logic [8:0] e, o;
    out_ready = 1'b1;
    send(8'd200, 8'd3, w);
    b = 0;
    while (!div_go && b < 10) begin
      @(negedge clk);
      b++;
    end
    n_checks++;
    if (div_go !== 1'b1) begin n_fail++; $display("FAIL rbusy_issue: div_go=%b want 1", div_go); end
    #2 reset = 1'b1;
    #1;
    n_checks += 3;
    if (div_go !== 1'b0) begin n_fail++; $display("FAIL rbusy_go: got %b want 0", div_go); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rbusy_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rbusy_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    send(8'd50, 8'd5, w);
    wait_obs(1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rbusy_timeout: got %0d results want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== {1'b0, 8'd10}) begin n_fail++; $display("FAIL rbusy_result: got %h want %h", o, {1'b0, 8'd10}); end
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL rbusy_extra: got %0d stray results want 0", obs_q.size()); end
  endtask

  task automatic test_protocol;
    n_checks += 2;
    if (drop_err != 0) begin n_fail++; $display("FAIL go_dropped_early: got %0d want 0", drop_err); end
    if (stab_err != 0) begin n_fail++; $display("FAIL operands_unstable: got %0d want 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div0();
    test_mix();
    test_stall();
    test_back_to_back();
    test_reset_busy();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/std_div_issue.md
# std_div_issue

Sequential issue/collect front end for the multi-cycle unsigned divider (`std_div_pipe`). It accepts operand pairs on a valid/ready stream and buffers them in a DEPTH-entry FIFO. It drives the divider's go/done handshake one operation at a time and returns quotients, in order, on a valid/ready output stream. Divide-by-zero is resolved locally without occupying the divider.

## Interface
- `WIDTH`, default 32: operand and quotient width; must match the attached divider.
- `DEPTH`, default 4: operand FIFO entries; power of two, ≥2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state immediately.
- `in_valid` input, 1 bit: operand pair present.
- `in_ready` output, 1 bit: FIFO can accept; equals !full.
- `in_left` input, WIDTH bits: dividend.
- `in_right` input, WIDTH bits: divisor.
- `out_valid` output, 1 bit: result register holds a result.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_data` output, WIDTH bits: quotient.
- `out_div0` output, 1 bit: result came from a zero divisor.
- `div_go` output, 1 bit: registered go to the divider.
- `div_left` output, WIDTH bits: registered dividend to the divider.
- `div_right` output, WIDTH bits: registered divisor to the divider.
- `div_out` input, WIDTH bits: divider quotient.
- `div_done` input, 1 bit: divider completion.

## Operation
- FIFO push on `in_valid && in_ready`. Pop only on issue completion. No pass-through: a full FIFO keeps `in_ready`=0 even in a pop cycle.
- Result slot is "free" when `out_valid`=0, or when `out_valid && out_ready` in this cycle.
- FSM states IDLE and BUSY. Reset state is IDLE.
- IDLE, FIFO non-empty, slot free, head `right`≠0:
  - Latch head into `div_left`/`div_right`.
  - Set `div_go`=1.
  - Go to BUSY.
- IDLE, FIFO non-empty, slot free, head `right`==0 (bypass):
  - Pop the head.
  - Load `out_data`=all-ones and `out_div0`=1; set `out_valid`=1.
  - Stay in IDLE. The divider is not touched.
- BUSY: hold `div_go`=1 and hold the operands stable until `div_done`=1. Then:
  - Capture `div_out` into `out_data` with `out_div0`=0; set `out_valid`=1.
  - Pop the head.
  - Clear `div_go`.
  - Go to IDLE.
- `div_go` is registered, so it is low for at least one cycle between operations. This lets the divider clear its running/done state. `div_done` seen in IDLE is ignored.
- At most one operation is in flight. Results leave in acceptance order.
- The output register clears `out_valid` on `out_valid && out_ready` unless it is reloaded in the same cycle. Reload takes priority.
- Occupancy counter runs 0..DEPTH. Pointers wrap modulo DEPTH. Simultaneous push and pop leaves the count unchanged.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_div0`=0, `div_go`=0, `div_left`=0, `div_right`=0. FIFO is empty; FSM is in IDLE.
- Reset mid-operation: `div_go` drops asynchronously and queued and in-flight operations are discarded. The divider sees go=0 and clears itself.
- Issue latency: an operand accepted at edge N into an empty FIFO, with the slot free, gives `div_go`=1 after edge N+1.
- Completion: `div_done` high in cycle D gives `out_valid`=1 and `div_go`=0 after edge D. The next issue can raise `div_go` after edge D+1 at the earliest.
- Bypass latency: a right=0 head reaching IDLE with the slot free gives `out_valid` one edge later.
- Back-to-back bypasses proceed at one per cycle while `out_ready`=1.
- Output stalled (`out_valid`=1, `out_ready`=0): no new issue occurs, the FIFO keeps accepting until full, and `div_go` stays 0.

## Test plan
- WIDTH=8, push (100,7) with a behavioural divider model → `div_go` rises and holds until done. Then `out_data`=14, `out_div0`=0, and `div_go` is low for ≥1 cycle afterwards.
- Push (9,0) → no `div_go` pulse; `out_data`=0xFF and `out_div0`=1 one cycle after issue eligibility.
- Push 4 pairs (20,3),(5,0),(255,16),(0,9) with `out_ready`=1 → in-order outputs 6, 0xFF(div0), 15, 0. Exactly 3 divider operations.
- Hold `out_ready`=0 and push 5 pairs with DEPTH=4 → `in_ready` falls after 4 accepted plus 1 in the result slot. No `div_go` while the slot is full. Releasing `out_ready` drains all pairs in order.
- Simultaneous push and pop at occupancy 3 → occupancy stays 3 and pointer wrap is correct across 10+ operations.
- Assert `reset` while BUSY → `div_go`=0 and `out_valid`=0 immediately. After release, a new pair (50,5) returns 10.
